data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind a valid/ready
// request/response pair with a fixed, parameterised response latency.
//
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   req_valid/req_ready     request handshake (ready only when idle)
//   req_write/addr/be/wdata request payload, latched on accept
//   resp_valid/resp_ready   response handshake, payload held until taken
//   resp_rdata/resp_err     load data (0 for stores/errors), error flag
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;

    logic        l_write;
    logic [31:0] l_addr;
    logic [3:0]  l_be;
    logic [31:0] l_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic          enter_resp;
    logic          c_write;
    logic [31:0]   c_addr;
    logic [3:0]    c_be;
    logic [31:0]   c_wdata;
    logic          c_err;
    logic [AW-1:0] c_idx;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // With LATENCY=1 the response is produced on the accept edge itself,
    // so the live request is used while idle, the latched copy otherwise.
    assign c_write = (state == IDLE) ? req_write : l_write;
    assign c_addr  = (state == IDLE) ? req_addr  : l_addr;
    assign c_be    = (state == IDLE) ? req_be    : l_be;
    assign c_wdata = (state == IDLE) ? req_wdata : l_wdata;

    assign c_err = (c_addr[1:0] != 2'b00) ||
                   ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign c_idx = c_addr[AW+1:2];

    assign enter_resp = (state != RESP) && (state_nx == RESP);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nx = RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            RESP: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            l_write    <= 1'b0;
            l_addr     <= 32'd0;
            l_be       <= 4'd0;
            l_wdata    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (req_valid && req_ready) begin
                l_write <= req_write;
                l_addr  <= req_addr;
                l_be    <= req_be;
                l_wdata <= req_wdata;
            end
            if (enter_resp) begin
                resp_err <= c_err;
                if (c_err || c_write) resp_rdata <= 32'd0;
                else                  resp_rdata <= mem[c_idx];
            end
        end
    end

    // Storage is never reset; the reset term stops a held-in-reset
    // request from writing on the LATENCY=1 path.
    always_ff @(posedge clock) begin
        if (reset && enter_resp && c_write && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed tests for data_mem_responder
// with DEPTH_WORDS=256 and LATENCY=2.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Presents one request, then scrambles the inputs after the accept
    // edge. lat counts edges from accept (inclusive) to resp_valid.
    task automatic send(input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int lat);
        @(negedge clock);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_be    = be;
        req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_be    = ~be;
        req_wdata = ~wd;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic finish_resp();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs ready=%b valid=%b want 1 0",
                     req_ready, resp_valid);
        end
        checks++;
        if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data rdata=%h err=%b want 0 0",
                     resp_rdata, resp_err);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_store_load();
        int lat;
        send(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat);
        checks++;
        if (lat !== LAT || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL store_resp lat=%0d err=%b rdata=%h want %0d 0 0",
                     lat, resp_err, resp_rdata, LAT);
        end
        finish_resp();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_done valid=%b ready=%b want 0 1",
                     resp_valid, req_ready);
        end
        send(1'b0, 32'h10, 4'h0, 32'h0, lat);
        checks++;
        if (lat !== LAT || resp_err !== 1'b0 ||
            resp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_10 lat=%0d err=%b rdata=%h want %0d 0 deadbeef",
                     lat, resp_err, resp_rdata, LAT);
        end
        finish_resp();
    endtask

    task automatic test_byte_lanes();
        int lat;
        send(1'b1, 32'h10, 4'b0010, 32'h0000AA00, lat);
        finish_resp();
        send(1'b0, 32'h10, 4'h0, 32'h0, lat);
        checks++;
        if (resp_rdata !== 32'hDEADAAEF || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL lane1 rdata=%h err=%b want deadaaef 0",
                     resp_rdata, resp_err);
        end
        finish_resp();
        send(1'b1, 32'h10, 4'b0000, 32'h55555555, lat);
        checks++;
        if (resp_err !== 1'b0) begin
            errors++;
            $display("FAIL be0_err err=%b want 0", resp_err);
        end
        finish_resp();
        send(1'b0, 32'h10, 4'h0, 32'h0, lat);
        checks++;
        if (resp_rdata !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL be0_keep rdata=%h want deadaaef", resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_errors();
        int lat;
        send(1'b0, 32'h12, 4'h0, 32'h0, lat);
        checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL misalign err=%b rdata=%h want 1 0",
                     resp_err, resp_rdata);
        end
        finish_resp();
        send(1'b0, 32'h400, 4'h0, 32'h0, lat);
        checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL range err=%b rdata=%h want 1 0",
                     resp_err, resp_rdata);
        end
        finish_resp();
        send(1'b1, 32'h13, 4'hF, 32'h00000000, lat);
        checks++;
        if (resp_err !== 1'b1) begin
            errors++;
            $display("FAIL st_misalign err=%b want 1", resp_err);
        end
        finish_resp();
        send(1'b0, 32'h10, 4'h0, 32'h0, lat);
        checks++;
        if (resp_rdata !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL st_err_keep rdata=%h want deadaaef", resp_rdata);
        end
        finish_resp();
        send(1'b1, 32'h3FC, 4'hF, 32'hA5A5A5A5, lat);
        finish_resp();
        send(1'b0, 32'h3FC, 4'h0, 32'h0, lat);
        checks++;
        if (resp_err !== 1'b0 || resp_rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL top_word err=%b rdata=%h want 0 a5a5a5a5",
                     resp_err, resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_stall();
        int lat;
        logic [31:0] rd0;
        logic        er0;
        resp_ready = 1'b0;
        send(1'b0, 32'h10, 4'h0, 32'h0, lat);
        rd0 = resp_rdata;
        er0 = resp_err;
        checks++;
        if (rd0 !== 32'hDEADAAEF || er0 !== 1'b0) begin
            errors++;
            $display("FAIL stall_data rdata=%h err=%b want deadaaef 0",
                     rd0, er0);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
                resp_rdata !== rd0 || resp_err !== er0) begin
                errors++;
                $display("FAIL stall_hold%0d valid=%b ready=%b rdata=%h want 1 0 %h",
                         i, resp_valid, req_ready, resp_rdata, rd0);
            end
        end
        resp_ready = 1'b1;
        finish_resp();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release valid=%b ready=%b want 0 1",
                     resp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        send(1'b0, 32'h3FC, 4'h0, 32'h0, lat);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        @(posedge clock);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_accept ready=%b valid=%b want 1 0",
                     req_ready, resp_valid);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checks++;
        if (lat !== LAT || resp_rdata !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL b2b_load lat=%0d rdata=%h want %0d deadaaef",
                     lat, resp_rdata, LAT);
        end
        finish_resp();
    endtask

    task automatic test_reset_wait();
        int lat;
        send(1'b1, 32'h20, 4'hF, 32'h11111111, lat);
        finish_resp();
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_be    = 4'hF;
        req_wdata = 32'h12345678;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rw_inwait ready=%b want 0", req_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_async ready=%b valid=%b want 1 0",
                     req_ready, resp_valid);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        send(1'b0, 32'h20, 4'h0, 32'h0, lat);
        checks++;
        if (resp_rdata !== 32'h11111111) begin
            errors++;
            $display("FAIL rw_discard rdata=%h want 11111111", resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_reset_resp();
        int lat;
        resp_ready = 1'b0;
        send(1'b1, 32'h24, 4'hF, 32'h0BADCAFE, lat);
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rr_drop valid=%b ready=%b want 0 1",
                     resp_valid, req_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        resp_ready = 1'b1;
        send(1'b0, 32'h24, 4'h0, 32'h0, lat);
        checks++;
        if (resp_rdata !== 32'h0BADCAFE) begin
            errors++;
            $display("FAIL rr_kept rdata=%h want 0badcafe", resp_rdata);
        end
        finish_resp();
    endtask

    initial begin
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_be     = 4'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_stall();
        test_back_to_back();
        test_reset_wait();
        test_reset_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
